// File: rtl/game_pkg.sv
// game_pkg: shared state encoding and counter widths for the game-over judge
package game_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        OVER
    } judge_state_t;

    localparam int LIVES_W = 3;
    localparam int KILLS_W = 8;
    localparam int SCORE_W = 16;

endpackage

// File: rtl/game_over_judge_sec_tick.sv
// sec_tick: divides clk by CLK_HZ into a one-cycle pulse per second while running
module sec_tick #(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_run,
    output logic o_tick
);

    localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

    logic [CW-1:0] r_cnt;

    assign o_tick = i_run && (r_cnt == CW'(CLK_HZ - 1));

    // cycle counter, restarts whenever the round is not running
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else
            r_cnt <= (!i_run || o_tick) ? '0 : r_cnt + 1'b1;
    end

endmodule

// File: rtl/game_over_judge.sv
// game_over_judge: tracks lives/kills/score per round and flags game over; optional round timer via GAMEOVER_TIMER_EN
module game_over_judge
    import game_pkg::*;
#(
    parameter int INIT_LIVES   = 3,
    parameter int MAX_LIVES    = 7,
    parameter int KILL_TARGET  = 20,
    parameter int KILL_POINTS  = 10,
    parameter int CLK_HZ       = 100_000_000,
    parameter int TIME_LIMIT_S = 120
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable_game_classic,
    input  logic               enable_game_infinity,
    input  logic               start_protect,
    input  logic               mytank_hit,
    input  logic [3:0]         enytank_kill,
    input  logic               reward_life,
    output logic               gameover_classic,
    output logic               gameover_infinity,
    output logic               win,
    output logic [LIVES_W-1:0] lives,
    output logic [KILLS_W-1:0] kills,
    output logic [SCORE_W-1:0] score,
    output logic [7:0]         time_left
);

    localparam int KW1 = KILLS_W + 1;
    localparam int SW1 = SCORE_W + 1;

    judge_state_t       r_state, w_next;
    logic               r_mode;
    logic               r_go_c, r_go_i, r_win;
    logic [LIVES_W-1:0] r_lives, w_lives_nx;
    logic [KILLS_W-1:0] r_kills, w_kills_nx;
    logic [SCORE_W-1:0] r_score, w_score_nx;
    logic [KILLS_W:0]   w_kills_sum;
    logic [SCORE_W:0]   w_score_sum;
    logic [2:0]         w_n;
    logic               w_start, w_en_mode, w_both_low;
    logic               w_hit, w_up, w_dn;
    logic               w_lose, w_win, w_timeout;

    assign w_start    = enable_game_classic ^ enable_game_infinity;
    assign w_en_mode  = r_mode ? enable_game_infinity : enable_game_classic;
    assign w_both_low = ~enable_game_classic & ~enable_game_infinity;

    assign w_n = 3'(enytank_kill[0]) + 3'(enytank_kill[1]) + 3'(enytank_kill[2]) + 3'(enytank_kill[3]);

    assign w_kills_sum = {1'b0, r_kills} + KW1'(w_n);
    assign w_kills_nx  = w_kills_sum[KILLS_W] ? '1 : w_kills_sum[KILLS_W-1:0];
    assign w_score_sum = {1'b0, r_score} + SW1'(w_n) * SW1'(KILL_POINTS);
    assign w_score_nx  = w_score_sum[SCORE_W] ? '1 : w_score_sum[SCORE_W-1:0];

    assign w_hit      = mytank_hit & ~start_protect;
    assign w_up       = reward_life & ~w_hit & (r_lives != LIVES_W'(MAX_LIVES));
    assign w_dn       = w_hit & ~reward_life & (r_lives != '0);
    assign w_lives_nx = w_up ? r_lives + 1'b1 : w_dn ? r_lives - 1'b1 : r_lives;

    assign w_lose = (w_lives_nx == '0) | w_timeout;
    assign w_win  = ~r_mode & (w_kills_nx >= KILLS_W'(KILL_TARGET)) & ~w_lose;

`ifdef GAMEOVER_TIMER_EN
    logic       w_tick;
    logic [7:0] r_time_left;

    sec_tick #(.CLK_HZ(CLK_HZ)) u_sec_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_run  (r_state == PLAY),
        .o_tick (w_tick)
    );

    assign w_timeout = r_mode & w_tick & (r_time_left == 8'd1);
    assign time_left = r_time_left;

    // seconds remaining: loaded for infinity rounds, counts down during play, frozen otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_time_left <= '0;
        else if (r_state == IDLE && w_start)
            r_time_left <= enable_game_infinity ? 8'(TIME_LIMIT_S) : 8'd0;
        else if (r_state == PLAY && w_en_mode && r_mode && w_tick && r_time_left != '0)
            r_time_left <= r_time_left - 1'b1;
    end
`else
    assign w_timeout = 1'b0;
    assign time_left = '0;
`endif

    // round state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // round sequencing: start on a single enable, end on lose/win, abort on enable drop
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_start ? PLAY : IDLE;
            PLAY:    w_next = !w_en_mode ? IDLE : (w_lose | w_win) ? OVER : PLAY;
            OVER:    w_next = w_both_low ? IDLE : OVER;
            default: w_next = IDLE;
        endcase
    end

    // round counters and result flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode  <= 1'b0;
            r_lives <= '0;
            r_kills <= '0;
            r_score <= '0;
            r_win   <= 1'b0;
            r_go_c  <= 1'b0;
            r_go_i  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_mode  <= enable_game_infinity;
                        r_lives <= LIVES_W'(INIT_LIVES);
                        r_kills <= '0;
                        r_score <= '0;
                        r_win   <= 1'b0;
                    end
                end
                PLAY: begin
                    if (w_en_mode) begin
                        r_lives <= w_lives_nx;
                        r_kills <= w_kills_nx;
                        r_score <= w_score_nx;
                        r_win   <= w_win;
                    end
                end
                OVER: begin
                    r_go_c <= ~w_both_low & ~r_mode;
                    r_go_i <= ~w_both_low & r_mode;
                    if (w_both_low)
                        r_win <= 1'b0;
                end
                default: begin
                    r_go_c <= 1'b0;
                    r_go_i <= 1'b0;
                end
            endcase
        end
    end

    assign gameover_classic  = r_go_c;
    assign gameover_infinity = r_go_i;
    assign win               = r_win;
    assign lives             = r_lives;
    assign kills             = r_kills;
    assign score             = r_score;

endmodule

// File: tb/tb_game_over_judge.sv
// tb_game_over_judge: table vectors, directed corner sequences and random stimulus against a round-level reference model
module tb_game_over_judge;

`ifdef GAMEOVER_TIMER_EN
    localparam int CLK_HZ = 10;
    localparam int TLIM   = 3;
    localparam bit TIMER  = 1'b1;
`else
    localparam int CLK_HZ = 100_000_000;
    localparam int TLIM   = 120;
    localparam bit TIMER  = 1'b0;
`endif
    localparam int INIT = 3;
    localparam int MAXL = 7;
    localparam int TGT  = 20;
    localparam int PTS  = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ec = 1'b0, ei = 1'b0, prot = 1'b0, hit = 1'b0, rew = 1'b0;
    logic [3:0] kill = 4'h0;
    logic       gameover_classic, gameover_infinity, win;
    logic [2:0] lives;
    logic [7:0] kills;
    logic [15:0] score;
    logic [7:0] time_left;

    game_over_judge #(
        .INIT_LIVES(INIT), .MAX_LIVES(MAXL), .KILL_TARGET(TGT), .KILL_POINTS(PTS),
        .CLK_HZ(CLK_HZ), .TIME_LIMIT_S(TLIM)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .enable_game_classic  (ec),
        .enable_game_infinity (ei),
        .start_protect        (prot),
        .mytank_hit           (hit),
        .enytank_kill         (kill),
        .reward_life          (rew),
        .gameover_classic     (gameover_classic),
        .gameover_infinity    (gameover_infinity),
        .win                  (win),
        .lives                (lives),
        .kills                (kills),
        .score                (score),
        .time_left            (time_left)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: 0 = waiting for a round, 1 = round running, 2 = round finished
    int m_phase, m_mode, m_lives, m_kills, m_score, m_tl, m_tcnt;
    bit m_gc, m_gi, m_win;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_mode = 0; m_lives = 0; m_kills = 0; m_score = 0;
        m_tl = 0; m_tcnt = 0; m_gc = 0; m_gi = 0; m_win = 0;
    endtask

    task automatic model_step();
        int  n, d;
        bit  tmo;
        tmo = 1'b0;
        if (m_phase == 0) begin
            if (ec != ei) begin
                m_phase = 1; m_mode = int'(ei); m_lives = INIT; m_kills = 0; m_score = 0;
                m_win = 0; m_tl = (TIMER && ei) ? TLIM : 0; m_tcnt = 0;
            end
        end else if (m_phase == 1) begin
            if (!(m_mode != 0 ? ei : ec)) begin
                m_phase = 0;
            end else begin
                n = $countones(kill);
                m_kills = (m_kills + n > 255) ? 255 : m_kills + n;
                m_score = (m_score + n * PTS > 65535) ? 65535 : m_score + n * PTS;
                d = int'(rew) - int'(hit && !prot);
                m_lives = m_lives + d;
                if (m_lives < 0) m_lives = 0;
                if (m_lives > MAXL) m_lives = MAXL;
                if (TIMER) begin
                    m_tcnt++;
                    if (m_tcnt == CLK_HZ) begin
                        m_tcnt = 0;
                        if (m_mode != 0 && m_tl > 0) begin
                            m_tl--;
                            tmo = (m_tl == 0);
                        end
                    end
                end
                if (m_lives == 0 || tmo) begin
                    m_phase = 2; m_win = 0;
                end else if (m_mode == 0 && m_kills >= TGT) begin
                    m_phase = 2; m_win = 1;
                end
            end
        end else begin
            if (!ec && !ei) begin
                m_phase = 0; m_gc = 0; m_gi = 0; m_win = 0;
            end else begin
                m_gc = (m_mode == 0); m_gi = (m_mode != 0);
            end
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".gameover_classic"},  gameover_classic,  m_gc);
        chk({tag, ".gameover_infinity"}, gameover_infinity, m_gi);
        chk({tag, ".win"},               win,               m_win);
        chk({tag, ".lives"},             lives,             m_lives);
        chk({tag, ".kills"},             kills,             m_kills);
        chk({tag, ".score"},             score,             m_score);
        chk({tag, ".time_left"},         time_left,         m_tl);
    endtask

    task automatic drive(input bit a_ec, a_ei, a_prot, a_hit, a_rew, input logic [3:0] a_kill);
        ec = a_ec; ei = a_ei; prot = a_prot; hit = a_hit; rew = a_rew; kill = a_kill;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string tag, input bit a_ec, a_ei, a_prot, a_hit, a_rew, input logic [3:0] a_kill);
        drive(a_ec, a_ei, a_prot, a_hit, a_rew, a_kill);
        check_model(tag);
    endtask

    typedef struct {
        bit         ec, ei, prot, hit, rew;
        logic [3:0] kill;
        bit         gc, gi, win;
        int         lives, kills, score;
    } vec_t;

    vec_t tbl [15];

    initial begin
        bit rec, rei;
        int cnt;
        // classic: three hits to lose, then release
        tbl[0]  = '{1, 0, 0, 0, 0, 4'h0, 0, 0, 0, 3, 0, 0};
        tbl[1]  = '{1, 0, 0, 1, 0, 4'h0, 0, 0, 0, 2, 0, 0};
        tbl[2]  = '{1, 0, 0, 1, 0, 4'h0, 0, 0, 0, 1, 0, 0};
        tbl[3]  = '{1, 0, 0, 1, 0, 4'h0, 0, 0, 0, 0, 0, 0};
        tbl[4]  = '{1, 0, 0, 0, 0, 4'h0, 1, 0, 0, 0, 0, 0};
        tbl[5]  = '{0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0};
        tbl[6]  = '{0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0};
        // classic: four kills per cycle reaches the target on the fifth cycle
        tbl[7]  = '{1, 0, 0, 0, 0, 4'h0, 0, 0, 0, 3, 0, 0};
        tbl[8]  = '{1, 0, 0, 0, 0, 4'hF, 0, 0, 0, 3, 4, 40};
        tbl[9]  = '{1, 0, 0, 0, 0, 4'hF, 0, 0, 0, 3, 8, 80};
        tbl[10] = '{1, 0, 0, 0, 0, 4'hF, 0, 0, 0, 3, 12, 120};
        tbl[11] = '{1, 0, 0, 0, 0, 4'hF, 0, 0, 0, 3, 16, 160};
        tbl[12] = '{1, 0, 0, 0, 0, 4'hF, 0, 0, 1, 3, 20, 200};
        tbl[13] = '{1, 0, 0, 0, 0, 4'hF, 1, 0, 1, 3, 20, 200};
        tbl[14] = '{0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 3, 20, 200};

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_model("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].ec, tbl[i].ei, tbl[i].prot, tbl[i].hit, tbl[i].rew, tbl[i].kill);
            chk($sformatf("vec%0d.gameover_classic", i),  gameover_classic,  tbl[i].gc);
            chk($sformatf("vec%0d.gameover_infinity", i), gameover_infinity, tbl[i].gi);
            chk($sformatf("vec%0d.win", i),               win,               tbl[i].win);
            chk($sformatf("vec%0d.lives", i),             lives,             tbl[i].lives);
            chk($sformatf("vec%0d.kills", i),             kills,             tbl[i].kills);
            chk($sformatf("vec%0d.score", i),             score,             tbl[i].score);
        end

        // invulnerability, simultaneous hit+reward, lives ceiling
        step("prot_start", 1, 0, 0, 0, 0, 4'h0);
        step("prot_hit", 1, 0, 1, 1, 0, 4'h0);
        step("prot_hit", 1, 0, 1, 1, 0, 4'h0);
        chk("protect_lives", lives, 3);
        step("hit_rew", 1, 0, 0, 1, 1, 4'h0);
        chk("hit_reward_lives", lives, 3);
        repeat (6) step("reward", 1, 0, 0, 0, 1, 4'h0);
        chk("lives_saturate", lives, 7);
        step("abort", 0, 0, 0, 0, 0, 4'h0);
        chk("abort_no_gameover", gameover_classic, 0);
        step("both_en", 1, 1, 0, 0, 0, 4'h0);
        step("both_en", 1, 1, 0, 1, 0, 4'h0);
        chk("both_en_idle_lives", lives, 7);
        step("both_en_rel", 0, 0, 0, 0, 0, 4'h0);

        // kill reaching target and last life lost in the same cycle: lose has priority
        step("tie_start", 1, 0, 0, 0, 0, 4'h0);
        repeat (4) step("tie_kill", 1, 0, 0, 0, 0, 4'hF);
        step("tie_kill", 1, 0, 0, 0, 0, 4'h7);
        chk("tie_kills19", kills, 19);
        step("tie_hit", 1, 0, 0, 1, 0, 4'h0);
        step("tie_hit", 1, 0, 0, 1, 0, 4'h0);
        chk("tie_lives1", lives, 1);
        step("tie_both", 1, 0, 0, 1, 0, 4'h1);
        step("tie_over", 1, 0, 0, 0, 0, 4'h0);
        chk("tie_gameover", gameover_classic, 1);
        chk("tie_win", win, 0);
        chk("tie_kills", kills, 20);
        step("tie_rel", 0, 0, 0, 0, 0, 4'h0);

        // infinity: kill target is irrelevant, only lives end the round
        step("inf_start", 0, 1, 0, 0, 0, 4'h0);
        repeat (6) step("inf_kill", 0, 1, 0, 0, 0, 4'hF);
        chk("inf_no_win_kills", kills, 24);
        chk("inf_no_gameover", gameover_infinity, 0);
        repeat (3) step("inf_hit", 0, 1, 0, 1, 0, 4'h0);
        step("inf_over", 0, 1, 0, 0, 0, 4'h0);
        chk("inf_gameover", gameover_infinity, 1);
        chk("inf_classic_low", gameover_classic, 0);
        step("inf_rel", 0, 0, 0, 0, 0, 4'h0);

`ifdef GAMEOVER_TIMER_EN
        step("tmr_start", 0, 1, 0, 0, 0, 4'h0);
        chk("tmr_load", time_left, TLIM);
        cnt = 0;
        while (!gameover_infinity && cnt < 100) begin
            step("tmr_run", 0, 1, 0, 0, 0, 4'h0);
            cnt++;
        end
        chk("timer_cycles", cnt, CLK_HZ * TLIM + 1);
        chk("timer_time_left", time_left, 0);
        step("tmr_rel", 0, 0, 0, 0, 0, 4'h0);
`endif

        // asynchronous reset in the middle of a round
        step("rst_start", 1, 0, 0, 0, 0, 4'h0);
        step("rst_kill", 1, 0, 0, 0, 0, 4'h3);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_model("async_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ec = 1'b0;
        step("post_rst", 0, 0, 0, 0, 0, 4'h0);

        // random play against the reference model
        rec = 1'b0; rei = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 29) == 0) {rec, rei} = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) prot = ~prot;
            step("rand", rec, rei, prot, $urandom_range(0, 11) == 0, $urandom_range(0, 15) == 0,
                 {$urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
